// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU and the ALU control decoder:
//   - 4-bit sel operation codes (ALU_ADD .. ALU_SLTU)
//   - FSM state encoding used by seq_alu
//   - is_shift(): true for the three shift opcodes
//   - is_legal(): true for every assigned opcode
// Both the ALU and its control decoder import this package so the opcode
// encoding lives in exactly one place.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

  function automatic logic is_legal(input logic [3:0] sel);
    return (sel == ALU_ADD) || (sel == ALU_SUB) || (sel == ALU_OR)  ||
           (sel == ALU_AND) || (sel == ALU_XOR) || is_shift(sel)    ||
           (sel == ALU_SLT) || (sel == ALU_SLTU);
  endfunction

endpackage

// File: rtl/seq_alu_shift_step.sv
// -----------------------------------------------------------------------------
// seq_alu_shift_step
// One-bit shift step used by the iterative shifter of seq_alu.
// Ports:
//   i_data [WIDTH-1:0] : value to shift
//   i_sel  [3:0]       : ALU_SLL / ALU_SRL / ALU_SRA (anything else passes through)
//   o_data [WIDTH-1:0] : value shifted by one bit position
// -----------------------------------------------------------------------------
module seq_alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [3:0]       i_sel,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_sel)
      ALU_SLL: o_data = {i_data[WIDTH-2:0], 1'b0};
      ALU_SRL: o_data = {1'b0, i_data[WIDTH-1:1]};
      // arithmetic right shift: the sign bit is copied into the vacated MSB
      ALU_SRA: o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Multi-cycle integer ALU for the RV32I execute stage. Operands and the 4-bit
// sel code arrive over a valid/ready handshake; result and flags leave over a
// second valid/ready handshake. Logic/arithmetic ops take one cycle; shifts
// iterate one bit per cycle unless the barrel shifter is compiled in.
//
// Build option:
//   SEQ_ALU_FAST_SHIFT_EN : when defined, shifts use a single-cycle barrel
//                           shifter; the SHIFT state and counter are not built.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (in_ready depends on out_ready)
//   sel [3:0]            : operation code (see alu_pkg)
//   a, b [WIDTH-1:0]     : operands, shift amount is b[SHW-1:0]
//   out_valid / out_ready: output handshake
//   result [WIDTH-1:0]   : operation result
//   zf, cf, vf, sf       : zero, carry, overflow, sign flags
//   illegal              : sel was an unassigned code
// -----------------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             cf,
  output logic             vf,
  output logic             sf,
  output logic             illegal
);

  alu_state_t       r_state;
  alu_state_t       w_state_next;

  logic [WIDTH-1:0] r_result;
  logic             r_zf;
  logic             r_cf;
  logic             r_vf;
  logic             r_sf;
  logic             r_illegal;

  logic             w_accept;
  logic             w_go_shift;
  logic [SHW-1:0]   w_shamt;

  // single-cycle datapath
  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  logic             w_add_vf;
  logic             w_slt;
  logic             w_sltu;
  logic [WIDTH-1:0] w_shift_res;
  logic [WIDTH-1:0] w_res;
  logic             w_cf;
  logic             w_vf;
  logic             w_ill;

  assign w_shamt  = b[SHW-1:0];
  assign w_accept = in_valid && in_ready;

  // sub reuses the adder as a + ~b + 1, so cf=1 means "no borrow"
  assign w_is_sub = (sel == ALU_SUB);
  assign w_b_op   = w_is_sub ? ~b : b;
  assign w_sum    = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
  // overflow: both adder inputs share a sign that differs from the sum's sign
  assign w_add_vf = (a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_slt    = ($signed(a) < $signed(b));
  assign w_sltu   = (a < b);

`ifdef SEQ_ALU_FAST_SHIFT_EN
  // barrel shifter: every shift completes in the accept cycle
  always_comb begin
    w_shift_res = a;
    case (sel)
      ALU_SLL: w_shift_res = a << w_shamt;
      ALU_SRL: w_shift_res = a >> w_shamt;
      ALU_SRA: w_shift_res = WIDTH'($signed(a) >>> w_shamt);
      default: w_shift_res = a;
    endcase
  end

  assign w_go_shift = 1'b0;
`else
  // iterative shifter: the single-cycle path only handles shamt==0 (result=a);
  // everything else runs through the SHIFT state below
  logic [SHW-1:0]   r_cnt;
  logic [3:0]       r_sel;
  logic [WIDTH-1:0] w_step;

  assign w_shift_res = a;
  assign w_go_shift  = is_shift(sel) && (w_shamt != '0);

  seq_alu_shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .i_data (r_result),
    .i_sel  (r_sel),
    .o_data (w_step)
  );
`endif

  always_comb begin
    w_res = '0;
    w_cf  = 1'b0;
    w_vf  = 1'b0;
    w_ill = 1'b0;
    case (sel)
      ALU_ADD, ALU_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_cf  = w_sum[WIDTH];
        w_vf  = w_add_vf;
      end
      ALU_OR:   w_res = a | b;
      ALU_AND:  w_res = a & b;
      ALU_XOR:  w_res = a ^ b;
      ALU_SLL, ALU_SRL, ALU_SRA: w_res = w_shift_res;
      ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
      ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_sltu};
      default: begin
        w_res = '0;
        w_ill = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_go_shift ? ST_SHIFT : ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        // a completing output transfer frees the unit in the same cycle
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_state_next = w_go_shift ? ST_SHIFT : ST_DONE;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
`ifndef SEQ_ALU_FAST_SHIFT_EN
      ST_SHIFT: begin
        if (r_cnt == SHW'(1)) begin
          w_state_next = ST_DONE;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result / flag registers. Only written on accept or while shifting, so they
  // stay frozen in DONE until the consumer takes them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_zf      <= 1'b0;
      r_cf      <= 1'b0;
      r_vf      <= 1'b0;
      r_sf      <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept && !w_go_shift) begin
      r_result  <= w_res;
      r_zf      <= (w_res == '0);
      r_cf      <= w_cf;
      r_vf      <= w_vf;
      r_sf      <= w_res[WIDTH-1];
      r_illegal <= w_ill;
    end
`ifndef SEQ_ALU_FAST_SHIFT_EN
    else if (w_accept) begin
      // start of an iterative shift: the result register becomes the shifter
      r_result  <= a;
      r_zf      <= 1'b0;
      r_cf      <= 1'b0;
      r_vf      <= 1'b0;
      r_sf      <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      // flags track the running value; they are final on the last step
      r_result  <= w_step;
      r_zf      <= (w_step == '0);
      r_sf      <= w_step[WIDTH-1];
    end
`endif
  end

`ifndef SEQ_ALU_FAST_SHIFT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sel <= ALU_ADD;
    end else if (w_accept && w_go_shift) begin
      r_cnt <= w_shamt;
      r_sel <= sel;
    end else if (r_state == ST_SHIFT) begin
      r_cnt <= r_cnt - SHW'(1);
    end
  end
`endif

  assign result  = r_result;
  assign zf      = r_zf;
  assign cf      = r_cf;
  assign vf      = r_vf;
  assign sf      = r_sf;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Self-checking bench for seq_alu (WIDTH=32). Expected values come from a
// behavioural model using plain integer arithmetic. Define
// SEQ_ALU_FAST_SHIFT_EN to check the barrel-shifter build (latency 1 for all).
// -----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    sel = 4'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          zf, cf, vf, sf, illegal;

  int n_chk = 0;
  int n_bad = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zf        (zf),
    .cf        (cf),
    .vf        (vf),
    .sf        (sf),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] res;
    logic        zf;
    logic        cf;
    logic        vf;
    logic        sf;
    logic        ill;
  } exp_t;

  // Reference: integer arithmetic straight from the operation definitions.
  function automatic exp_t model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx;
    longint sy;
    longint r;
    int     sh;
    e  = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    case (s)
      4'd0: begin
        e.res = x + y;
        e.cf  = ({32'd0, x} + {32'd0, y}) > 64'hFFFF_FFFF;
        r     = sx + sy;
        e.vf  = (r > SMAX) || (r < SMIN);
      end
      4'd1: begin
        e.res = x - y;
        e.cf  = (x >= y);
        r     = sx - sy;
        e.vf  = (r > SMAX) || (r < SMIN);
      end
      4'd4:  e.res = x | y;
      4'd5:  e.res = x & y;
      4'd7:  e.res = x ^ y;
      4'd8:  e.res = x << sh;
      4'd9:  e.res = x >> sh;
      4'd10: e.res = 32'($signed(x) >>> sh);
      4'd13: e.res = (sx < sy) ? 32'd1 : 32'd0;
      4'd15: e.res = (x < y) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.zf = (e.res == 32'd0);
    e.sf = e.res[31];
    return e;
  endfunction

  function automatic int exp_lat(input logic [3:0] s, input logic [31:0] y);
`ifdef SEQ_ALU_FAST_SHIFT_EN
    return 1;
`else
    if ((s == 4'd8 || s == 4'd9 || s == 4'd10) && y[4:0] != 5'd0)
      return 1 + int'(y[4:0]);
    return 1;
`endif
  endfunction

  // One full transaction, starting and ending 1 time unit after a rising edge.
  task automatic do_op(input string tag, input logic [3:0] s, input logic [31:0] x,
                       input logic [31:0] y, input int stall);
    exp_t e;
    int   lat;
    e = model(s, x, y);
    sel = s; a = x; b = y; in_valid = 1'b1;
    #1;
    chk({tag, " in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // scramble inputs after accept: captured values must be unaffected
    sel = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat(s, y)));
    repeat (stall) begin
      @(posedge clk); #1;
    end
    chk({tag, " out_valid"}, out_valid, 1'b1);
    chk({tag, " result"}, result, e.res);
    chk({tag, " flags zcvsi"}, {zf, cf, vf, sf, illegal}, {e.zf, e.cf, e.vf, e.sf, e.ill});
    $display("op %s sel=%h a=%h b=%h -> result=%h zcvsi=%b%b%b%b%b lat=%0d",
             tag, s, x, y, result, zf, cf, vf, sf, illegal, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " drain"}, out_valid, 1'b0);
  endtask

  logic [3:0]  legal_ops [10];
  logic [3:0]  fast_ops  [7];
  logic [31:0] corners   [5];

  initial begin
    logic [3:0]  s;
    logic [31:0] x, y;
    exp_t        e;

    legal_ops = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd13, 4'd15};
    fast_ops  = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd7, 4'd13, 4'd15};
    corners   = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset result", result, 32'h0);
    chk("reset flags", {zf, cf, vf, sf, illegal}, 5'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", in_ready, 1'b1);

    // ---- directed corner operations ----
    do_op("add ovf",  4'd0, 32'h7FFF_FFFF, 32'h1, 0);
    do_op("sub eq",   4'd1, 32'd5, 32'd5, 0);
    do_op("sra 31",   4'd10, 32'h8000_0000, 32'd31, 0);
    do_op("srl 0",    4'd9, 32'hDEAD_BEEF, 32'd0, 0);
    do_op("sll 1",    4'd8, 32'h8000_0001, 32'd1, 1);
    do_op("slt",      4'd13, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("sltu",     4'd15, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("illegal",  4'd3, 32'h1234_5678, 32'h9, 0);
    do_op("sub brw",  4'd1, 32'd3, 32'd7, 0);

    // ---- backpressure, then transfer + accept on the same edge ----
    sel = 4'd0; a = 32'd100; b = 32'd23; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp out_valid", out_valid, 1'b1);
    chk("bp result", result, 32'd123);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp hold result", result, 32'd123);
      chk("bp in_ready", in_ready, 1'b0);
    end
    sel = 4'd7; a = 32'h0000_F0F0; b = 32'h0000_FF00; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp release in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp xor out_valid", out_valid, 1'b1);
    chk("bp xor result", result, 32'h0000_0FF0);
    $display("op backpressure xor -> result=%h", result);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // ---- back-to-back throughput with out_ready high ----
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s = fast_ops[$urandom_range(0, 6)];
      x = $urandom; y = $urandom;
      e = model(s, x, y);
      sel = s; a = x; b = y; in_valid = 1'b1;
      #1;
      chk("b2b in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      chk("b2b out_valid", out_valid, 1'b1);
      chk("b2b result", result, e.res);
      $display("op b2b sel=%h a=%h b=%h -> result=%h", s, x, y, result);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b drain", out_valid, 1'b0);
    out_ready = 1'b0;

    // ---- random operations ----
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) s = 4'($urandom);
      else s = legal_ops[$urandom_range(0, 9)];
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      do_op("rand", s, x, y, $urandom_range(0, 2));
    end

    // ---- asynchronous reset in the middle of a shift ----
    sel = 4'd8; a = 32'h0000_0003; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst result", result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst in_ready", in_ready, 1'b1);
    do_op("add after rst", 4'd0, 32'd3, 32'd4, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle integer ALU that consumes the 4-bit `sel` operation code produced by the ALU control decoder and executes it on two operands. It sits in the execute stage of the RV32I datapath. Operands and `sel` arrive over a valid/ready handshake; the result and flags leave over a second valid/ready handshake. Logic and arithmetic operations finish in one cycle. Shifts iterate one bit per cycle unless the barrel shifter is compiled in.

## Interface
- `WIDTH`, 32: operand and result width; must be a power of two, at least 8.
- `SHW`, $clog2(WIDTH): shift-amount width; derived, not overridden.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands and `sel` are valid.
- `in_ready` out 1: block can accept an operation.
- `sel` in 4: operation code (encoding under Operation).
- `a`, `b` in WIDTH: operands; shift amount is `b[SHW-1:0]`.
- `out_valid` out 1: result and flags are valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out WIDTH: operation result.
- `zf`, `cf`, `vf`, `sf` out 1 each: zero, carry, overflow, sign flags.
- `illegal` out 1: `sel` was an unassigned code.

## Operation
- Encoding:
  - 0000 add; 0001 sub.
  - 0100 or; 0101 and; 0111 xor.
  - 1000 sll; 1001 srl; 1010 sra.
  - 1101 slt (signed); 1111 sltu (unsigned).
  - All other codes are illegal.
- Acceptance: an operation is accepted on a rising edge where `in_valid && in_ready`. At that edge `a`, `b` and `sel` are captured; later input changes have no effect.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, accept, non-shift or illegal op: go to DONE.
  - IDLE, accept, shift op with shamt≠0: go to SHIFT and load the counter with shamt.
  - IDLE, accept, shift op with shamt=0: go to DONE with result=`a`.
  - SHIFT: shift one bit per cycle and decrement the counter. When the counter goes 1→0, go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE, or accept a new op in the same cycle (see handshake rules).
- Handshake rules:
  - `in_ready` = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from `out_ready`.
  - In DONE, `result`, flags and `illegal` are held stable until `out_ready`.
- Arithmetic:
  - sub is computed as a + ~b + 1.
  - `cf` = carry-out of the adder (sub: 1 means no borrow, i.e. a ≥ b unsigned).
  - `vf` = signed overflow for add/sub.
  - slt/sltu produce 0 or 1 in `result[0]`.
  - sra replicates `a[WIDTH-1]`.
- Flags:
  - `zf` = (result==0).
  - `sf` = result[WIDTH-1].
  - `cf` and `vf` are 0 for every op except add/sub.
- Illegal `sel`: result=0, `zf`=1, all other flags 0, `illegal`=1, 1-cycle latency.

## Timing
- Reset (asserted asynchronously, at any time including mid-shift):
  - state=IDLE, `out_valid`=0, `result`=0, all flags=0, `illegal`=0, counter=0.
  - `in_ready`=1 one cycle after deassertion.
  - An in-flight op is discarded.
- Latency, from accept edge to `out_valid`:
  - non-shift, illegal, or shamt=0: 1 cycle.
  - shift: 1+shamt cycles; shamt=WIDTH-1 gives WIDTH cycles.
- Throughput with `out_ready` tied high: one non-shift op per cycle (back-to-back accept in DONE).
- `out_valid` deasserts on the edge that completes the output transfer, unless a new non-shift op is accepted on that edge. In that case it stays high with the new result.

## Configuration
- `SEQ_ALU_FAST_SHIFT_EN` defined:
  - shifts use a single-cycle barrel shifter, so every op has 1-cycle latency.
  - SHIFT state and counter are not built.
- Undefined: iterative shifter as described above.
- Handshake and results are identical in both builds; only latency differs.

## Structure
- `alu_pkg` holds:
  - `sel` code localparams (`ALU_ADD` … `ALU_SLTU`);
  - state enum values;
  - a function `is_shift(sel)`.
- The same package is shared with ALU control so both ends use one encoding.
- Sub-module `seq_alu_shift_step`: one-bit sll/srl/sra step. Instantiated once in the iterative build; replaced by the barrel shifter under `SEQ_ALU_FAST_SHIFT_EN`.

## Test plan
- Reset mid-shift: accept sll with `b`=20, assert `rst_n`=0 at cycle 5 → `out_valid`=0 and `result`=0 immediately; after release, `in_ready`=1 and the next add of 3+4 returns 7.
- add 0x7FFFFFFF+1 → `result`=0x80000000, `vf`=1, `cf`=0, `sf`=1, latency 1. sub 5−5 → `result`=0, `zf`=1, `cf`=1.
- sra 0x80000000 by 31 → `result`=0xFFFFFFFF after 32 cycles. srl by 0 → `result`=`a` after 1 cycle.
- slt with a=0xFFFFFFFF, b=1 → `result`=1. sltu on the same operands → `result`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles → `result` stable, `in_ready`=0. Raise `out_ready` with `in_valid` on an xor (a=0xF0F0, b=0xFF00) → transfer and accept on the same edge; next cycle `result`=0x0FF0.
- Illegal `sel`=0011 → `illegal`=1, `result`=0, `zf`=1. Repeat the run with `SEQ_ALU_FAST_SHIFT_EN` and confirm all shifts have latency 1.
